conv33_window_gen: RTL and testbench

Upstream producer for the 3x3 convolution datapath. It accepts a raster-order pixel stream and keeps two line buffers. It assembles the 3x3 sliding window and drives the nine window taps plus conv33_en straight into the 3x3 calc stage. The output is a valid-only (no padding) convolution window stream: (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows per frame.

---
 rtl/conv_pkg.sv | 17 +
 rtl/conv33_window_gen_if.sv | 32 +++
 rtl/conv33_line_buf.sv | 25 ++
 rtl/conv33_window_gen.sv | 126 ++++++++++++
 tb/tb_conv33_window_gen.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared geometry and width helpers for the 3x3 convolution datapath.
package conv_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int IMG_WIDTH   = 28;
    localparam int IMG_HEIGHT  = 28;
    localparam int KERNEL_SIZE = 3;

    // Address width that stays legal for degenerate one-entry geometries.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

endpackage

// File: rtl/conv33_window_gen_if.sv
// Pixel-in / window-out bundle between the stream source, the window generator and the calc stage.
interface conv33_window_gen_if #(
    parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH
);

    logic signed [DATA_WIDTH-1:0] pix_in;
    logic                         pix_valid;
    logic                         frame_start;

    logic signed [DATA_WIDTH-1:0] data_0_0, data_0_1, data_0_2;
    logic signed [DATA_WIDTH-1:0] data_1_0, data_1_1, data_1_2;
    logic signed [DATA_WIDTH-1:0] data_2_0, data_2_1, data_2_2;
    logic                         conv33_en;
    logic                         frame_done;

    modport master (
        output pix_in, pix_valid, frame_start,
        input  data_0_0, data_0_1, data_0_2,
        input  data_1_0, data_1_1, data_1_2,
        input  data_2_0, data_2_1, data_2_2,
        input  conv33_en, frame_done
    );

    modport slave (
        input  pix_in, pix_valid, frame_start,
        output data_0_0, data_0_1, data_0_2,
        output data_1_0, data_1_1, data_1_2,
        output data_2_0, data_2_1, data_2_2,
        output conv33_en, frame_done
    );

endinterface

// File: rtl/conv33_line_buf.sv
// One-row delay line: combinational read of the old entry, write of the new one on the same edge.
module conv33_line_buf #(
    parameter  int DEPTH      = conv_pkg::IMG_WIDTH,
    parameter  int DATA_WIDTH = conv_pkg::DATA_WIDTH,
    localparam int ADDR_W     = conv_pkg::addr_w(DEPTH)
) (
    input  logic                         clk,
    input  logic [ADDR_W-1:0]            addr,
    input  logic                         we,
    input  logic signed [DATA_WIDTH-1:0] wdata,
    output logic signed [DATA_WIDTH-1:0] rdata
);

    logic signed [DATA_WIDTH-1:0] mem [DEPTH];

    // Read is asynchronous so the caller sees the pre-write value in the writing cycle.
    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv33_window_gen.sv
// Raster pixel stream to 3x3 sliding window, valid-only (no padding) windows.
module conv33_window_gen #(
    parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
    parameter int IMG_WIDTH  = conv_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT = conv_pkg::IMG_HEIGHT
) (
    input logic                clk,
    input logic                rst,
    conv33_window_gen_if.slave bus
);

    import conv_pkg::KERNEL_SIZE;
    import conv_pkg::addr_w;

    localparam int CW = addr_w(IMG_WIDTH);
    localparam int RW = addr_w(IMG_HEIGHT);

    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] MIN_COL  = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] MIN_ROW  = RW'(KERNEL_SIZE - 1);

    logic [CW-1:0] col, cur_col, next_col;
    logic [RW-1:0] row, cur_row, next_row;

    logic signed [DATA_WIDTH-1:0] lb1_out;
    logic signed [DATA_WIDTH-1:0] lb0_out;
    logic signed [DATA_WIDTH-1:0] new_tap [KERNEL_SIZE];
    logic signed [DATA_WIDTH-1:0] win [KERNEL_SIZE][KERNEL_SIZE];

    logic en_next, done_next;
    logic conv33_en_q, frame_done_q;

    // frame_start overrides the counters for the pixel it accompanies.
    always_comb begin
        cur_col  = bus.frame_start ? '0 : col;
        cur_row  = bus.frame_start ? '0 : row;
        next_col = cur_col + CW'(1);
        next_row = cur_row;
        if (cur_col == LAST_COL) begin
            next_col = '0;
            next_row = (cur_row == LAST_ROW) ? '0 : cur_row + RW'(1);
        end

        en_next   = bus.pix_valid && (cur_row >= MIN_ROW) && (cur_col >= MIN_COL);
        done_next = en_next && (cur_row == LAST_ROW) && (cur_col == LAST_COL);

        new_tap[0] = lb0_out;
        new_tap[1] = lb1_out;
        new_tap[2] = bus.pix_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (bus.pix_valid) begin
            col <= next_col;
            row <= next_row;
        end
    end

    // Taps shift left one column per accepted pixel; stale columns after a row wrap are masked by en_next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (bus.pix_valid) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][KERNEL_SIZE-1] <= new_tap[r];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv33_en_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            conv33_en_q  <= en_next;
            frame_done_q <= done_next;
        end
    end

    // lb1 holds the previous row, lb0 the row before that (fed from lb1's outgoing value).
    conv33_line_buf #(
        .DEPTH      (IMG_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lb1 (
        .clk   (clk),
        .addr  (cur_col),
        .we    (bus.pix_valid),
        .wdata (bus.pix_in),
        .rdata (lb1_out)
    );

    conv33_line_buf #(
        .DEPTH      (IMG_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lb0 (
        .clk   (clk),
        .addr  (cur_col),
        .we    (bus.pix_valid),
        .wdata (lb1_out),
        .rdata (lb0_out)
    );

    assign bus.data_0_0   = win[0][0];
    assign bus.data_0_1   = win[0][1];
    assign bus.data_0_2   = win[0][2];
    assign bus.data_1_0   = win[1][0];
    assign bus.data_1_1   = win[1][1];
    assign bus.data_1_2   = win[1][2];
    assign bus.data_2_0   = win[2][0];
    assign bus.data_2_1   = win[2][1];
    assign bus.data_2_2   = win[2][2];
    assign bus.conv33_en  = conv33_en_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv33_window_gen.sv
// Scoreboard bench for conv33_window_gen on a 4x4 image with directed and random streams.
module tb_conv33_window_gen;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    typedef logic [8:0][DW-1:0] win_t;

    typedef struct {
        win_t taps;
        logic done;
        int   due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    conv33_window_gen_if #(.DATA_WIDTH(DW)) bus ();

    conv33_window_gen #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb [$];
    win_t seen_log [$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_win = 0;
    int n_done = 0;

    logic [DW-1:0] img [H][W];
    int mrow = 0;
    int mcol = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic win_t mk(input int a, input int b, input int c,
                                input int d, input int e, input int f,
                                input int g, input int h, input int i);
        win_t w;
        w[0] = DW'(a); w[1] = DW'(b); w[2] = DW'(c);
        w[3] = DW'(d); w[4] = DW'(e); w[5] = DW'(f);
        w[6] = DW'(g); w[7] = DW'(h); w[8] = DW'(i);
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [71:0] got, input logic [71:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, got, req, $time);
        end
    endtask

    // Reference: remember the frame as an image; a pixel at (r,c) with r,c >= 2 closes the window ending there.
    task automatic applyStimulus(input logic [DW-1:0] pix, input logic valid, input logic fs);
        exp_t e;
        bus.pix_in      = pix;
        bus.pix_valid   = valid;
        bus.frame_start = fs;
        if (valid) begin
            if (fs) begin
                mrow = 0;
                mcol = 0;
            end
            img[mrow][mcol] = pix;
            if (mrow >= 2 && mcol >= 2) begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        e.taps[r*3+c] = img[mrow-2+r][mcol-2+c];
                e.done = (mrow == H-1) && (mcol == W-1);
                e.due  = cyc + 1;
                sb.push_back(e);
            end
            mcol++;
            if (mcol == W) begin
                mcol = 0;
                mrow++;
                if (mrow == H) mrow = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, 1'b0);
    endtask

    task automatic applyReset();
        rst             = 1'b1;
        bus.pix_valid   = 1'b0;
        bus.frame_start = 1'b0;
        sb.delete();
        mrow = 0;
        mcol = 0;
        @(negedge clk);
        checkOutput("reset_taps", {bus.data_0_0, bus.data_0_1, bus.data_0_2,
                                   bus.data_1_0, bus.data_1_1, bus.data_1_2,
                                   bus.data_2_0, bus.data_2_1, bus.data_2_2}, '0);
        checkOutput("reset_conv33_en", 72'(bus.conv33_en), '0);
        checkOutput("reset_frame_done", 72'(bus.frame_done), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic sendFrame(input int base, input logic fs, input int bub_a, input int bub_b, input int blen);
        for (int i = 0; i < W*H; i++) begin
            applyStimulus(DW'(base + i), 1'b1, fs && (i == 0));
            if (i + 1 == bub_a || i + 1 == bub_b) idle(blen);
        end
    endtask

    // Monitor: every presented window must match the oldest expectation at exactly its due cycle.
    always @(negedge clk) begin : monitor
        win_t got;
        exp_t e;
        if (!rst) begin
            got[0] = bus.data_0_0; got[1] = bus.data_0_1; got[2] = bus.data_0_2;
            got[3] = bus.data_1_0; got[4] = bus.data_1_1; got[5] = bus.data_1_2;
            got[6] = bus.data_2_0; got[7] = bus.data_2_1; got[8] = bus.data_2_2;
            if (bus.frame_done && !bus.conv33_en)
                checkOutput("frame_done_without_en", 72'(bus.frame_done), '0);
            if (bus.conv33_en) begin
                n_win++;
                if (bus.frame_done) n_done++;
                seen_log.push_back(got);
                if (sb.size() == 0) begin
                    checkOutput("spurious_window", 72'(bus.conv33_en), '0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("window_cycle", 72'(cyc), 72'(e.due));
                    checkOutput("window_taps", got, e.taps);
                    checkOutput("window_frame_done", 72'(bus.frame_done), 72'(e.done));
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                checkOutput("missing_window", 72'(bus.conv33_en), 72'(1));
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        int w0;
        int d0;
        int pat [4];
        logic v;
        logic fs;
        pat = '{-128, -1, 127, 0};
        bus.pix_in      = '0;
        bus.pix_valid   = 1'b0;
        bus.frame_start = 1'b0;
        #1;
        applyReset();

        $display("[TB] continuous frame 1..16");
        w0 = n_win; d0 = n_done;
        sendFrame(1, 1'b1, 0, 0, 0);
        idle(3);
        checkOutput("t1_window_count", 72'(n_win - w0), 72'(4));
        checkOutput("t2_frame_done_count", 72'(n_done - d0), 72'(1));
        checkOutput("t1_first_window", seen_log[w0], mk(1,2,3, 5,6,7, 9,10,11));
        checkOutput("t2_last_window", seen_log[w0+3], mk(6,7,8, 10,11,12, 14,15,16));

        $display("[TB] frame with bubbles");
        w0 = n_win; d0 = n_done;
        sendFrame(1, 1'b1, 6, 11, 3);
        idle(3);
        checkOutput("t3_window_count", 72'(n_win - w0), 72'(4));
        checkOutput("t3_frame_done_count", 72'(n_done - d0), 72'(1));
        checkOutput("t3_first_window", seen_log[w0], mk(1,2,3, 5,6,7, 9,10,11));

        $display("[TB] back-to-back frames");
        w0 = n_win;
        sendFrame(1, 1'b1, 0, 0, 0);
        sendFrame(101, 1'b1, 0, 0, 0);
        idle(3);
        checkOutput("t4_window_count", 72'(n_win - w0), 72'(8));
        checkOutput("t4_second_first_window", seen_log[w0+4], mk(101,102,103, 105,106,107, 109,110,111));

        $display("[TB] mid-frame reset");
        for (int i = 0; i < 10; i++) applyStimulus(DW'(200 + i), 1'b1, i == 0);
        applyReset();
        w0 = n_win;
        sendFrame(1, 1'b0, 0, 0, 0);
        idle(3);
        checkOutput("t5_window_count", 72'(n_win - w0), 72'(4));
        checkOutput("t5_first_window", seen_log[w0], mk(1,2,3, 5,6,7, 9,10,11));

        $display("[TB] signed pixels");
        w0 = n_win;
        for (int i = 0; i < W*H; i++) applyStimulus(DW'(pat[i % 4]), 1'b1, i == 0);
        idle(3);
        checkOutput("t6_window_count", 72'(n_win - w0), 72'(4));
        checkOutput("t6_first_window", seen_log[w0], mk(-128,-1,127, -128,-1,127, -128,-1,127));

        $display("[TB] random stream");
        for (int k = 0; k < 400; k++) begin
            v  = ($urandom_range(0, 99) < 70);
            fs = v ? ($urandom_range(0, 99) < 3) : ($urandom_range(0, 99) < 20);
            applyStimulus(DW'($urandom), v, fs);
            if (k == 200) applyReset();
        end
        idle(4);
        checkOutput("scoreboard_drained", 72'(sb.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
